// File: rtl/alu_op_issuer_pkg.sv
// rtl/alu_op_issuer_pkg.sv - shared unit codes, state encoding and default widths for alu_op_issuer
package alu_op_issuer_pkg;

   localparam int DEF_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 16;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_fun_decoder.sv
// rtl/alu_fun_decoder.sv - unit-select field to one-hot enable vector and result mux select
module alu_fun_decoder
   import alu_op_issuer_pkg::*;
(
   input  logic [1:0] unit_sel,
   output logic [3:0] enable_vec,
   output logic [1:0] mux_sel
);

   // enable_vec bit order is {shift, cmp, logic, arith}
   always_comb begin
      enable_vec = 4'b0000;
      unique case (unit_sel)
         UNIT_ARITH: enable_vec = 4'b0001;
         UNIT_LOGIC: enable_vec = 4'b0010;
         UNIT_CMP:   enable_vec = 4'b0100;
         UNIT_SHIFT: enable_vec = 4'b1000;
      endcase
      mux_sel = unit_sel;
   end

endmodule

// File: rtl/alu_op_issuer.sv
// rtl/alu_op_issuer.sv - issues one ALU command at a time over unit enable/flag and returns the result
// Optional flag-wait timeout compiled in with ALU_OP_ISSUER_TIMEOUT_EN.
module alu_op_issuer
   import alu_op_issuer_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int RES_W   = 2 * DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_A,
   input  logic [DATA_W-1:0] cmd_B,
   input  logic [3:0]        cmd_fun,
   output logic [DATA_W-1:0] unit_A,
   output logic [DATA_W-1:0] unit_B,
   output logic [1:0]        unit_fun,
   output logic              arith_enable,
   output logic              logic_enable,
   output logic              cmp_enable,
   output logic              shift_enable,
   input  logic [RES_W-1:0]  arith_out,
   input  logic [DATA_W-1:0] logic_out,
   input  logic [DATA_W-1:0] cmp_out,
   input  logic [DATA_W-1:0] shift_out,
   input  logic              arith_flag,
   input  logic              logic_flag,
   input  logic              cmp_flag,
   input  logic              shift_flag,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [RES_W-1:0]  res_data,
   output logic [1:0]        res_unit,
   output logic              res_err
);

   if (TIMEOUT < 1) begin : g_timeout_check
      $error("alu_op_issuer: TIMEOUT must be at least 1");
   end

   logic [3:0]        dec_en;
   logic [1:0]        dec_sel;

   state_e            state_q, state_d;
   logic [3:0]        en_q, en_d;
   logic [DATA_W-1:0] unit_a_q, unit_a_d;
   logic [DATA_W-1:0] unit_b_q, unit_b_d;
   logic [1:0]        unit_fun_q, unit_fun_d;
   logic [1:0]        sel_q, sel_d;
   logic              res_valid_q, res_valid_d;
   logic [RES_W-1:0]  res_data_q, res_data_d;
   logic [1:0]        res_unit_q, res_unit_d;
   logic [RES_W-1:0]  unit_res;
   logic              flag_hit;

`ifdef ALU_OP_ISSUER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             res_err_q, res_err_d;
`endif

   alu_fun_decoder u_dec (
      .unit_sel   (cmd_fun[3:2]),
      .enable_vec (dec_en),
      .mux_sel    (dec_sel)
   );

   always_comb begin
      state_d     = state_q;
      en_d        = en_q;
      unit_a_d    = unit_a_q;
      unit_b_d    = unit_b_q;
      unit_fun_d  = unit_fun_q;
      sel_d       = sel_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_unit_d  = res_unit_q;
`ifdef ALU_OP_ISSUER_TIMEOUT_EN
      cnt_d       = cnt_q;
      res_err_d   = res_err_q;
`endif

      // Masking with the held enable makes flags of unselected units irrelevant.
      flag_hit = |({shift_flag, cmp_flag, logic_flag, arith_flag} & en_q);

      unique case (sel_q)
         UNIT_ARITH: unit_res = arith_out;
         UNIT_LOGIC: unit_res = RES_W'(logic_out);
         UNIT_CMP:   unit_res = RES_W'(cmp_out);
         UNIT_SHIFT: unit_res = RES_W'(shift_out);
      endcase

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               unit_a_d   = cmd_A;
               unit_b_d   = cmd_B;
               unit_fun_d = cmd_fun[1:0];
               en_d       = dec_en;
               sel_d      = dec_sel;
               state_d    = ST_EXEC;
`ifdef ALU_OP_ISSUER_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         ST_EXEC: begin
            if (flag_hit) begin
               res_data_d  = unit_res;
               res_unit_d  = sel_q;
               res_valid_d = 1'b1;
               en_d        = 4'b0000;
               state_d     = ST_RESP;
`ifdef ALU_OP_ISSUER_TIMEOUT_EN
               res_err_d   = 1'b0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               res_data_d  = '0;
               res_unit_d  = sel_q;
               res_err_d   = 1'b1;
               res_valid_d = 1'b1;
               en_d        = 4'b0000;
               state_d     = ST_RESP;
            end else begin
               cnt_d       = cnt_q + CNT_W'(1);
`endif
            end
         end
         ST_RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         en_q        <= '0;
         unit_a_q    <= '0;
         unit_b_q    <= '0;
         unit_fun_q  <= '0;
         sel_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_unit_q  <= '0;
`ifdef ALU_OP_ISSUER_TIMEOUT_EN
         cnt_q       <= '0;
         res_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         en_q        <= en_d;
         unit_a_q    <= unit_a_d;
         unit_b_q    <= unit_b_d;
         unit_fun_q  <= unit_fun_d;
         sel_q       <= sel_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_unit_q  <= res_unit_d;
`ifdef ALU_OP_ISSUER_TIMEOUT_EN
         cnt_q       <= cnt_d;
         res_err_q   <= res_err_d;
`endif
      end
   end

   assign cmd_ready    = (state_q == ST_IDLE);
   assign unit_A       = unit_a_q;
   assign unit_B       = unit_b_q;
   assign unit_fun     = unit_fun_q;
   assign arith_enable = en_q[0];
   assign logic_enable = en_q[1];
   assign cmp_enable   = en_q[2];
   assign shift_enable = en_q[3];
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
   assign res_unit     = res_unit_q;
`ifdef ALU_OP_ISSUER_TIMEOUT_EN
   assign res_err      = res_err_q;
`else
   assign res_err      = 1'b0;
`endif

endmodule
